// File: rtl/fft_pkg.sv
// Shared fixed-point definitions for the FFT datapath: complex word layout,
// bank state encoding and the real-sample to Q16.16 complex conversion.
package fft_pkg;

    localparam int CPLX_W = 64;
    localparam int PART_W = 32;
    localparam int FRAC   = 16;

    localparam int RE_MSB = 63;
    localparam int RE_LSB = 32;
    localparam int IM_MSB = 31;
    localparam int IM_LSB = 0;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_t;

    // Convert an already sign-extended real sample with frac_in fractional
    // bits into a complex Q16.16 word with zero imaginary part. The shift
    // only adds fractional bits, so the result always fits in 32 bits.
    function automatic logic [CPLX_W-1:0] to_q16(
        input logic signed [PART_W-1:0] sample,
        input int unsigned              frac_in
    );
        logic [CPLX_W-1:0] word;
        word                 = {CPLX_W{1'b0}};
        word[RE_MSB:RE_LSB]  = sample <<< (FRAC - frac_in);
        word[IM_MSB:IM_LSB]  = {PART_W{1'b0}};
        return word;
    endfunction

endpackage

// File: rtl/fft_in_frame_buffer_if.sv
// Sample-in / frame-out bus of the FFT input frame buffer.
interface fft_in_frame_buffer_if
    import fft_pkg::*;
#(
    parameter int N    = 16,
    parameter int IN_W = 16
);
    logic                  in_valid;
    logic [IN_W-1:0]       in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [N*CPLX_W-1:0]   out_data;
    logic                  overflow;

    // Producer / consumer side (drives samples, accepts frames).
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  overflow
    );

    // Frame buffer side.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data,
        output overflow
    );

endinterface

// File: rtl/fft_frame_bank.sv
// One bank of N complex words: single write port, whole-frame flat read port.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int N  = 16,
    parameter int AW = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       widx,
    input  logic [CPLX_W-1:0]   wdata,
    output logic [N*CPLX_W-1:0] rdata
);

    logic [N-1:0][CPLX_W-1:0] mem_r;

    // Word storage; cleared on reset so the presented frame reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_r <= '0;
        end else if (we) begin
            mem_r[widx] <= wdata;
        end
    end

    assign rdata = mem_r;

endmodule

// File: rtl/fft_in_frame_buffer.sv
// Ping-pong frame buffer: converts real samples to Q16.16 complex words,
// fills one bank while the other waits for the FFT to take it.
module fft_in_frame_buffer
    import fft_pkg::*;
#(
    parameter int N       = 16,
    parameter int IN_W    = 16,
    parameter int FRAC_IN = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    fft_in_frame_buffer_if.slave  bus
);

    localparam int            AW       = $clog2(N);
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    bank_state_t          bank_st_r [0:1];
    logic                 wb_r;
    logic                 rb_r;
    logic [AW-1:0]        wr_idx_r;
    logic                 overflow_r;

    logic                 accept_s;
    logic                 drop_s;
    logic                 last_s;
    logic                 consume_s;
    logic [1:0]           we_s;
    logic [CPLX_W-1:0]    wr_word_s;
    logic [N*CPLX_W-1:0]  rdata0_s;
    logic [N*CPLX_W-1:0]  rdata1_s;
    logic [N*CPLX_W-1:0]  out_data_s;

    assign wr_word_s = to_q16(32'(signed'(bus.in_data)), FRAC_IN);

    // Decode this cycle's write/drop/consume events from the bank states.
    always_comb begin
        accept_s  = 1'b0;
        drop_s    = 1'b0;
        we_s      = 2'b00;
        if (bus.in_valid) begin
            if (bank_st_r[wb_r] == BANK_EMPTY) begin
                accept_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            accept_s = 1'b0;
            drop_s   = 1'b0;
        end
        last_s    = accept_s && (wr_idx_r == LAST_IDX);
        consume_s = (bank_st_r[rb_r] == BANK_FULL) && bus.out_ready;
        if (accept_s) begin
            if (wb_r) begin
                we_s = 2'b10;
            end else begin
                we_s = 2'b01;
            end
        end else begin
            we_s = 2'b00;
        end
    end

    // Bank pointers, bank states, write index and sticky overflow.
    // A completing bank and the consumed bank are always different banks,
    // so both state updates can land on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_st_r[0] <= BANK_EMPTY;
            bank_st_r[1] <= BANK_EMPTY;
            wb_r         <= 1'b0;
            rb_r         <= 1'b0;
            wr_idx_r     <= '0;
            overflow_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                if (last_s) begin
                    wr_idx_r        <= '0;
                    bank_st_r[wb_r] <= BANK_FULL;
                    wb_r            <= ~wb_r;
                end else begin
                    wr_idx_r <= wr_idx_r + 1'b1;
                end
            end
            if (consume_s) begin
                bank_st_r[rb_r] <= BANK_EMPTY;
                rb_r            <= ~rb_r;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Present the bank at the read pointer.
    always_comb begin
        out_data_s = '0;
        if (rb_r) begin
            out_data_s = rdata1_s;
        end else begin
            out_data_s = rdata0_s;
        end
    end

    fft_frame_bank #(.N(N), .AW(AW)) u_bank0 (
        .clk   (clk),
        .rst   (rst),
        .we    (we_s[0]),
        .widx  (wr_idx_r),
        .wdata (wr_word_s),
        .rdata (rdata0_s)
    );

    fft_frame_bank #(.N(N), .AW(AW)) u_bank1 (
        .clk   (clk),
        .rst   (rst),
        .we    (we_s[1]),
        .widx  (wr_idx_r),
        .wdata (wr_word_s),
        .rdata (rdata1_s)
    );

    assign bus.out_valid = (bank_st_r[rb_r] == BANK_FULL);
    assign bus.out_data  = out_data_s;
    assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_fft_in_frame_buffer.sv
// Bench for fft_in_frame_buffer: scenario tasks checked against a
// frame-queue reference model of the ping-pong buffer.
module tb_fft_in_frame_buffer;

    localparam int N       = 16;
    localparam int IN_W    = 16;
    localparam int FRAC_IN = 8;

    typedef logic [63:0] frame_t [N];

    logic clk;
    logic rst;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: completed frames awaiting consumption, the frame
    // being collected, and the sticky drop flag.
    frame_t      done_q[$];
    logic [63:0] part_q[$];
    logic        ovf_m;

    fft_in_frame_buffer_if #(.N(N), .IN_W(IN_W)) bus_if ();

    fft_in_frame_buffer #(.N(N), .IN_W(IN_W), .FRAC_IN(FRAC_IN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_word(input logic [IN_W-1:0] s);
        int v;
        v = int'($signed(s)) * (1 << (16 - FRAC_IN));
        return {32'(v), 32'h0000_0000};
    endfunction

    function automatic logic [N*64-1:0] flatten(input frame_t f);
        logic [N*64-1:0] r;
        for (int i = 0; i < N; i++) r[64*i +: 64] = f[i];
        return r;
    endfunction

    function automatic void model_reset();
        done_q.delete();
        part_q.delete();
        ovf_m = 1'b0;
    endfunction

    // Drive one cycle of stimulus, advance the model, and land at edge+1.
    task automatic cycle(input logic v, input logic [IN_W-1:0] d, input logic r);
        int     pending;
        frame_t f;
        bus_if.in_valid  = v;
        bus_if.in_data   = d;
        bus_if.out_ready = r;
        pending = done_q.size();
        if (r && pending > 0) void'(done_q.pop_front());
        if (v) begin
            if (pending == 2) begin
                ovf_m = 1'b1;
            end else begin
                part_q.push_back(ref_word(d));
                if (part_q.size() == N) begin
                    for (int i = 0; i < N; i++) f[i] = part_q[i];
                    done_q.push_back(f);
                    part_q.delete();
                end
            end
        end
        @(posedge clk);
        #1;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = '0;
        bus_if.out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (bus_if.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_valid: got %0b expected 0", bus_if.out_valid);
        end
        tests_run++;
        if (bus_if.out_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_out_data: got %h expected 0", bus_if.out_data);
        end
        tests_run++;
        if (bus_if.overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_overflow: got %0b expected 0", bus_if.overflow);
        end
    endtask

    task automatic test_ramp();
        logic [N*64-1:0] exp;
        do_reset();
        for (int i = 0; i < N; i++) begin
            cycle(1'b1, 16'((i + 1) << 8), 1'b0);
            if (i == N - 2) begin
                tests_run++;
                if (bus_if.out_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL ramp_early_valid: got %0b expected 0", bus_if.out_valid);
                end
            end
        end
        for (int i = 0; i < N; i++) exp[64*i +: 64] = {16'(i + 1), 16'h0000, 32'h0000_0000};
        tests_run++;
        if (bus_if.out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL ramp_latency: out_valid got %0b expected 1", bus_if.out_valid);
        end
        tests_run++;
        if (bus_if.out_data !== exp) begin
            tests_failed++;
            $display("FAIL ramp_data: got %h expected %h", bus_if.out_data, exp);
        end
        tests_run++;
        if (bus_if.overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL ramp_overflow: got %0b expected 0", bus_if.overflow);
        end
    endtask

    task automatic test_negative();
        logic [N*64-1:0] exp;
        do_reset();
        for (int i = 0; i < N; i++) cycle(1'b1, 16'hFF80, 1'b0);
        for (int i = 0; i < N; i++) exp[64*i +: 64] = 64'hFFFF_8000_0000_0000;
        tests_run++;
        if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== exp) begin
            tests_failed++;
            $display("FAIL negative_data: valid %0b data %h expected valid 1 data %h",
                     bus_if.out_valid, bus_if.out_data, exp);
        end
    endtask

    task automatic test_overflow();
        logic [IN_W-1:0] smp [48];
        logic [N*64-1:0] exp1;
        logic [N*64-1:0] exp2;
        do_reset();
        for (int i = 0; i < 48; i++) begin
            smp[i] = 16'($urandom);
            cycle(1'b1, smp[i], 1'b0);
        end
        for (int i = 0; i < N; i++) begin
            exp1[64*i +: 64] = ref_word(smp[i]);
            exp2[64*i +: 64] = ref_word(smp[N + i]);
        end
        tests_run++;
        if (bus_if.overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_flag: got %0b expected 1", bus_if.overflow);
        end
        tests_run++;
        if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== exp1) begin
            tests_failed++;
            $display("FAIL ovf_frame1: valid %0b data %h expected %h", bus_if.out_valid, bus_if.out_data, exp1);
        end
        cycle(1'b0, '0, 1'b1);
        tests_run++;
        if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== exp2) begin
            tests_failed++;
            $display("FAIL ovf_frame2: valid %0b data %h expected %h", bus_if.out_valid, bus_if.out_data, exp2);
        end
        cycle(1'b0, '0, 1'b1);
        tests_run++;
        if (bus_if.out_valid !== 1'b0 || bus_if.overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_drained: valid %0b overflow %0b expected valid 0 overflow 1",
                     bus_if.out_valid, bus_if.overflow);
        end
    endtask

    task automatic test_stream();
        int   pulses;
        logic exp_v;
        do_reset();
        pulses = 0;
        for (int c = 0; c < 4 * N + 2; c++) begin
            cycle(c < 4 * N, 16'($urandom), 1'b1);
            exp_v = (c < 4 * N) && (c % N == N - 1);
            tests_run++;
            if (bus_if.out_valid !== exp_v) begin
                tests_failed++;
                $display("FAIL stream_valid c=%0d: got %0b expected %0b", c, bus_if.out_valid, exp_v);
            end
            if (exp_v && done_q.size() > 0) begin
                pulses++;
                tests_run++;
                if (bus_if.out_data !== flatten(done_q[0])) begin
                    tests_failed++;
                    $display("FAIL stream_data c=%0d: got %h expected %h", c, bus_if.out_data, flatten(done_q[0]));
                end
            end
        end
        tests_run++;
        if (pulses != 4 || bus_if.overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_summary: frames %0d overflow %0b expected 4 frames overflow 0",
                     pulses, bus_if.overflow);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 2 * N + 1; i++) cycle(1'b1, 16'($urandom), 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 7; i++) cycle(1'b1, 16'($urandom), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus_if.out_valid !== 1'b0 || bus_if.overflow !== 1'b0 || bus_if.out_data !== '0) begin
            tests_failed++;
            $display("FAIL midrst_async: valid %0b overflow %0b data %h expected all 0",
                     bus_if.out_valid, bus_if.overflow, bus_if.out_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) cycle(1'b1, 16'($urandom), 1'b0);
        tests_run++;
        if (bus_if.out_valid !== 1'b1 || done_q.size() != 1) begin
            tests_failed++;
            $display("FAIL midrst_valid: got %0b expected 1", bus_if.out_valid);
        end else if (bus_if.out_data !== flatten(done_q[0]) || bus_if.overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_frame: data %h overflow %0b expected %h overflow 0",
                     bus_if.out_data, bus_if.overflow, flatten(done_q[0]));
        end
    endtask

    task automatic test_gapped();
        int   accepted;
        int   guard;
        logic v;
        do_reset();
        accepted = 0;
        guard    = 0;
        while (accepted < N && guard < 400) begin
            v = (guard % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            cycle(v, 16'($urandom), 1'b0);
            if (v) accepted++;
            guard++;
            if (accepted == N / 2 && v) begin
                tests_run++;
                if (bus_if.out_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL gapped_early_valid: got %0b expected 0", bus_if.out_valid);
                end
            end
        end
        tests_run++;
        if (accepted != N || done_q.size() != 1) begin
            tests_failed++;
            $display("FAIL gapped_budget: accepted %0d expected %0d", accepted, N);
        end else if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== flatten(done_q[0])) begin
            tests_failed++;
            $display("FAIL gapped_frame: valid %0b data %h expected %h",
                     bus_if.out_valid, bus_if.out_data, flatten(done_q[0]));
        end
    endtask

    task automatic test_random();
        logic exp_v;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 4) == 0));
            exp_v = (done_q.size() > 0);
            tests_run++;
            if (bus_if.out_valid !== exp_v || bus_if.overflow !== ovf_m) begin
                tests_failed++;
                $display("FAIL random_ctrl c=%0d: valid %0b overflow %0b expected %0b %0b",
                         c, bus_if.out_valid, bus_if.overflow, exp_v, ovf_m);
            end else if (exp_v && bus_if.out_data !== flatten(done_q[0])) begin
                tests_failed++;
                $display("FAIL random_data c=%0d: got %h expected %h", c, bus_if.out_data, flatten(done_q[0]));
            end
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = '0;
        bus_if.out_ready = 1'b0;
        model_reset();
        test_reset();
        test_ramp();
        test_negative();
        test_overflow();
        test_stream();
        test_mid_reset();
        test_gapped();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
